// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS fetch stage: PC, imem read, IF/ID register, redirect/halt/stall handling.
// Optional perf counters under IF_STAGE_PERF_EN.
module if_stage #(
  parameter logic [31:0] PCINIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ifW,
  input  logic [1:0]  pcSel,
  input  logic [31:0] brTarget,
  input  logic [31:0] jTarget,
  input  logic        haltIn,
  output logic [31:0] ifinstr,
  output logic [31:0] ifnpc,
  output logic        ifvalid,
  output logic [31:0] fetchCnt,
  output logic [31:0] stallCnt
);

  typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;
  logic        fetching, redirect, halt_ev, advance;

  always_comb begin
    fetching = ifW && (state_q == FETCH);
    redirect = fetching && ((pcSel == 2'b01) || (pcSel == 2'b10));
    halt_ev  = fetching && !redirect && haltIn;
    advance  = fetching && !redirect && !haltIn && ihit;

    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;

    // Any advancing cycle that does not deliver a word leaves a bubble behind.
    if (ifW) begin
      instr_d = '0;
      npc_d   = '0;
      valid_d = 1'b0;
      if (redirect) begin
        pc_d = (pcSel == 2'b01) ? brTarget : jTarget;
      end else if (halt_ev) begin
        state_d = HALTED;
      end else if (advance) begin
        instr_d = iload;
        npc_d   = pc_q + 32'd4;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PCINIT;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign iREN    = (state_q == FETCH);
  assign iaddr   = pc_q;
  assign ifinstr = instr_q;
  assign ifnpc   = npc_q;
  assign ifvalid = valid_q;

`ifdef IF_STAGE_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        miss;

  assign miss = fetching && !redirect && !ihit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (advance && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (miss && (stall_cnt_q != 32'hFFFF_FFFF))    stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetchCnt = fetch_cnt_q;
  assign stallCnt = stall_cnt_q;
`else
  assign fetchCnt = '0;
  assign stallCnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized and directed checks of if_stage against a behavioural model.
module tb_if_stage;

  localparam logic [31:0] PCINIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ifW;
  logic [1:0]  pcSel;
  logic [31:0] brTarget;
  logic [31:0] jTarget;
  logic        haltIn;
  logic [31:0] ifinstr;
  logic [31:0] ifnpc;
  logic        ifvalid;
  logic [31:0] fetchCnt;
  logic [31:0] stallCnt;

  if_stage #(.PCINIT(PCINIT)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
    .ifW(ifW), .pcSel(pcSel), .brTarget(brTarget), .jTarget(jTarget), .haltIn(haltIn),
    .ifinstr(ifinstr), .ifnpc(ifnpc), .ifvalid(ifvalid), .fetchCnt(fetchCnt), .stallCnt(stallCnt)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference state: what the stage should hold, described at the level of fetch events.
  logic [31:0] m_pc, m_instr, m_npc, m_fcnt, m_scnt;
  logic        m_valid, m_halted;
  bit          perf_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = PCINIT; m_instr = '0; m_npc = '0; m_valid = 1'b0;
    m_halted = 1'b0; m_fcnt = '0; m_scnt = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".iaddr"},   iaddr,          m_pc);
    check({tag, ".iREN"},    {31'd0, iREN},  {31'd0, !m_halted});
    check({tag, ".ifinstr"}, ifinstr,        m_instr);
    check({tag, ".ifnpc"},   ifnpc,          m_npc);
    check({tag, ".ifvalid"}, {31'd0, ifvalid}, {31'd0, m_valid});
    check({tag, ".fetchCnt"}, fetchCnt,      perf_en ? m_fcnt : 32'd0);
    check({tag, ".stallCnt"}, stallCnt,      perf_en ? m_scnt : 32'd0);
  endtask

  task automatic step(input string tag, input logic hit, input logic [31:0] word, input logic w,
                      input logic [1:0] sel, input logic [31:0] br, input logic [31:0] jt,
                      input logic halt);
    bit redir;
    ihit = hit; iload = word; ifW = w; pcSel = sel; brTarget = br; jTarget = jt; haltIn = halt;
    redir = (sel == 2'd1) || (sel == 2'd2);
    if (w) begin
      if (!m_halted && !redir && !hit && m_scnt != 32'hFFFF_FFFF) m_scnt++;
      if (m_halted) begin
        m_instr = 0; m_npc = 0; m_valid = 0;
      end else if (redir) begin
        m_pc = (sel == 2'd1) ? br : jt;
        m_instr = 0; m_npc = 0; m_valid = 0;
      end else if (halt) begin
        m_halted = 1; m_instr = 0; m_npc = 0; m_valid = 0;
      end else if (hit) begin
        m_instr = word; m_npc = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
        if (m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
      end else begin
        m_instr = 0; m_npc = 0; m_valid = 0;
      end
    end
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    nRST = 1'b0;
    model_reset();
    #1;
    check({tag, ".rst_iaddr"}, iaddr, PCINIT);
    check({tag, ".rst_iREN"},  {31'd0, iREN}, 32'd1);
    check_all(tag);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  logic [31:0] s0;

  initial begin
`ifdef IF_STAGE_PERF_EN
    perf_en = 1'b1;
`else
    perf_en = 1'b0;
`endif
    nRST = 1'b0; ihit = 0; iload = 0; ifW = 1; pcSel = 0; brTarget = 0; jTarget = 0; haltIn = 0;
    model_reset();
    #12;
    check_all("reset");
    nRST = 1'b1;
    #1;

    // Sequential fetch 0,4,8
    step("seq0", 1, 32'h1111_0000, 1, 0, 0, 0, 0);
    check("seq0.addr4", iaddr, 32'd4);
    check("seq0.npc", ifnpc, 32'd4);
    step("seq1", 1, 32'h1111_0004, 1, 0, 0, 0, 0);
    step("seq2", 1, 32'h1111_0008, 1, 0, 0, 0, 0);
    check("seq2.instr", ifinstr, 32'h1111_0008);
    check("seq2.npc", ifnpc, 32'd12);

    // Miss then hit at 0x10
    step("jmp10", 1, 32'hDEAD_0000, 1, 2'd2, 0, 32'h10, 0);
    s0 = stallCnt;
    step("miss0", 0, 32'hBAD0_0000, 1, 0, 0, 0, 0);
    step("miss1", 0, 32'hBAD0_0001, 1, 0, 0, 0, 0);
    check("miss.pc", iaddr, 32'h10);
    step("hit10", 1, 32'h2222_0010, 1, 0, 0, 0, 0);
    check("hit10.npc", ifnpc, 32'h14);
    check("miss.scnt", stallCnt - s0, perf_en ? 32'd2 : 32'd0);

    // Stall holding the word from 0x20
    step("jmp20", 1, 32'hDEAD_0001, 1, 2'd2, 0, 32'h20, 0);
    step("hit20", 1, 32'h3333_0020, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall", $urandom_range(0, 1), $urandom, 0, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    check("stall.npc", ifnpc, 32'h24);
    check("stall.addr", iaddr, 32'h24);
    step("resume", 1, 32'h3333_0024, 1, 0, 0, 0, 0);
    check("resume.npc", ifnpc, 32'h28);

    // Branch at 0x40 squashes that word
    step("jmp40", 1, 32'hDEAD_0002, 1, 2'd2, 0, 32'h40, 0);
    step("br", 1, 32'h4444_0040, 1, 2'd1, 32'h100, 0, 0);
    check("br.addr", iaddr, 32'h100);
    check("br.bubble", {31'd0, ifvalid}, 32'd0);
    step("br.tgt", 1, 32'h5555_0100, 1, 0, 0, 0, 0);
    check("br.tgt.instr", ifinstr, 32'h5555_0100);

    // Jump beats halt, then halt alone freezes until reset
    step("jvh", 1, 32'hDEAD_0003, 1, 2'd2, 0, 32'h200, 1);
    check("jvh.addr", iaddr, 32'h200);
    check("jvh.iren", {31'd0, iREN}, 32'd1);
    step("halt", 1, 32'h6666_0200, 1, 0, 0, 0, 1);
    check("halt.iren", {31'd0, iREN}, 32'd0);
    for (int i = 0; i < 3; i++) step("halted", 1, $urandom, 1, 2'd1, 32'h300, 0, 0);
    check("halted.addr", iaddr, 32'h200);
    pulse_reset("halt_rst");
    step("post_rst", 1, 32'h7777_0000, 1, 0, 0, 0, 0);

    // Wrap around top of address space
    step("jwrap", 1, 32'hDEAD_0004, 1, 2'd2, 0, 32'hFFFF_FFFC, 0);
    step("wrap", 1, 32'h8888_FFFC, 1, 0, 0, 0, 0);
    check("wrap.addr", iaddr, 32'd0);
    check("wrap.npc", ifnpc, 32'd0);
    check("wrap.valid", {31'd0, ifvalid}, 32'd1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [1:0] sel;
      r = $urandom_range(0, 99);
      sel = (r < 8) ? 2'd1 : (r < 16) ? 2'd2 : (r < 20) ? 2'd3 : 2'd0;
      if ($urandom_range(0, 99) < 2 || (m_halted && $urandom_range(0, 9) == 0))
        pulse_reset("rnd_rst");
      step("rnd", 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 4) != 0), sel,
           $urandom, $urandom, 1'($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It holds the program counter, issues instruction-memory reads, and owns the IF/ID pipeline register that feeds decode, which in turn feeds the ID/EX register. It applies branch/jump redirects, inserts bubbles on fetch misses and redirects, freezes under hazard-unit stalls, and stops fetching once decode reports a halt.

## Interface
Parameters:
- PCINIT, 32'h0000_0000, PC value loaded at reset

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction memory returned iload this cycle
- iload  in  32  instruction word from memory
- iREN  out  1  instruction read enable
- iaddr  out  32  instruction address, equal to current PC
- ifW  in  1  pipeline advance enable from hazard unit; 0 means stall
- pcSel  in  2  00 sequential, 01 branch (from EX), 10 jump/jr (from ID), 11 treated as 00
- brTarget  in  32  resolved branch target
- jTarget  in  32  full jump/jr target, formed by decode
- haltIn  in  1  decode holds a HALT instruction
- ifinstr  out  32  IF/ID instruction
- ifnpc  out  32  IF/ID PC+4 of that instruction
- ifvalid  out  1  IF/ID holds a real instruction, not a bubble
- fetchCnt  out  32  instructions delivered (see Configuration)
- stallCnt  out  32  fetch-miss cycles (see Configuration)

## Operation
- States: FETCH, HALTED. Reset state is FETCH. Exit from HALTED is by reset only.
- iREN = (state == FETCH). iaddr = PC. Both are combinational from registers.
- Event priority when ifW=1, highest first:
  - Redirect: pcSel = 01 or 10. PC <= brTarget or jTarget. IF/ID <= bubble. ihit is ignored. haltIn is ignored in that cycle, because the older branch/jump squashes the halt.
  - Halt: haltIn=1. State <= HALTED. PC holds. IF/ID <= bubble.
  - Advance: state=FETCH and ihit=1. IF/ID <= {iload, PC+4, valid=1}. PC <= PC+4.
  - Miss: state=FETCH and ihit=0. PC holds. IF/ID <= bubble.
  - In HALTED: IF/ID <= bubble each cycle. PC holds.
- When ifW=0: PC, IF/ID and state all hold. pcSel and haltIn are ignored; the sourcing stage holds its request until ifW=1. ihit is dropped. Memory re-presents the word, because iaddr is unchanged.
- Bubble: ifinstr=0 (sll $0 nop), ifnpc=0, ifvalid=0.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag. Redirect targets are taken verbatim, with no alignment check.

## Timing
- Reset values (async): PC=PCINIT, ifinstr=0, ifnpc=0, ifvalid=0, state=FETCH, fetchCnt=0, stallCnt=0. The outputs are therefore iREN=1 and iaddr=PCINIT while nRST is low.
- Latency: an instruction accepted on edge N (ihit and ifW high) appears on ifinstr after edge N. iaddr shows the next PC after the same edge.
- Redirect costs one bubble in IF/ID. The target is fetched starting the cycle after the redirect edge.
- A stall holds every register. No instruction is lost or duplicated across a stall.
- Reset mid-operation abandons any outstanding fetch. Memory sees iaddr=PCINIT immediately.

## Configuration
- Macro IF_STAGE_PERF_EN.
- When defined:
  - fetchCnt increments on every Advance event.
  - stallCnt increments on every cycle with state=FETCH, ifW=1, ihit=0 and no redirect.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both clear only on reset.
- When undefined: fetchCnt and stallCnt are tied to 0 and no counter flops exist.

## Test plan
- Sequential fetch: reset with PCINIT=0, ihit=1, ifW=1 for 3 cycles. iaddr goes 0, 4, 8. ifinstr follows the iload words one cycle later, with ifnpc=4, 8, 12 and ifvalid=1.
- Miss then hit: ihit=0 for 2 cycles at PC=0x10, then 1. Two bubbles appear (ifvalid=0, ifinstr=0). PC holds at 0x10, then the word for 0x10 is delivered with ifnpc=0x14. stallCnt=2 with IF_STAGE_PERF_EN, 0 without.
- Stall: ifW=0 for 3 cycles while IF/ID holds instruction at 0x20. ifinstr, ifnpc and iaddr are unchanged for all 3 cycles. Advance resumes with no duplicate.
- Branch redirect: pcSel=01, brTarget=0x100 with ihit=1 at PC=0x40. IF/ID becomes a bubble, iaddr=0x100 next cycle, and the word at 0x40 is never delivered.
- Halt versus redirect: haltIn=1 with pcSel=10, jTarget=0x200. Result is PC=0x200 and state stays FETCH. Then haltIn=1 alone gives iREN=0 the next cycle, a constant bubble, and a frozen PC until nRST is pulsed, after which iaddr=PCINIT.
- PC wrap: redirect to 0xFFFF_FFFC, then ihit=1. Next iaddr=0, and ifnpc=0 with ifvalid=1.
